// File: rtl/dac_sweep_ctrl.sv
// DAC code sweep sequencer: steps the DAC through a code range, averages 2^navg
// ADC conversions per point and hands each (code, average) pair to a sink.
module dac_sweep_ctrl #(
  parameter int DW  = 12,
  parameter int AW  = 12,
  parameter int NL2 = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       go_i,
  input  logic                       abort_i,
  input  logic [DW-1:0]              code_start_i,
  input  logic [DW-1:0]              code_stop_i,
  input  logic [DW-1:0]              code_step_i,
  input  logic [$clog2(NL2+1)-1:0]   navg_i,
  output logic [DW-1:0]              dac_code_o,
  output logic                       conv_start_o,
  output logic                       conv_ack_o,
  input  logic                       conv_eoc_i,
  input  logic [AW-1:0]              adc_data_i,
  output logic                       smp_valid_o,
  input  logic                       smp_ready_i,
  output logic [DW-1:0]              smp_code_o,
  output logic [AW-1:0]              smp_data_o,
  output logic                       busy_o,
  output logic                       done_o
);

  // state   | meaning
  // IDLE    | waiting for go_i
  // START   | conv_start_o pulse for the current code
  // WAIT_LO | waiting for the conversion FSM to leave idle (eoc low)
  // WAIT_HI | conversion running, waiting for eoc high
  // ACC     | accumulate ADC result, conv_ack_o pulse
  // EMIT    | averaged sample offered to the sink
  // NEXT    | clear accumulator, advance code or finish
  // DONE    | done_o pulse

  localparam int NW = $clog2(NL2 + 1);
  localparam int XW = AW + NL2;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_LO, S_WAIT_HI, S_ACC, S_EMIT, S_NEXT, S_DONE
  } state_t;

  state_t          state;
  logic [DW-1:0]   code;
  logic [DW-1:0]   stop_r;
  logic [DW-1:0]   step_r;
  logic [NW-1:0]   navg_r;
  logic [XW-1:0]   acc;
  logic [NL2:0]    cnt;
  logic            abort_pend;

  logic [NW-1:0]   navg_clamp;
  logic [XW-1:0]   acc_sum;
  logic [NL2:0]    cnt_inc;
  logic [NL2:0]    cnt_target;
  logic [DW:0]     sum;
  logic            abort_now;

  assign navg_clamp = (navg_i > NW'(NL2)) ? NW'(NL2) : navg_i;
  assign acc_sum    = acc + XW'(adc_data_i);
  assign cnt_inc    = cnt + 1'b1;
  assign cnt_target = (NL2 + 1)'(1) << navg_r;
  // One extra bit so a code overflow is seen as "past stop" instead of wrapping
  assign sum        = {1'b0, code} + {1'b0, step_r};
  assign abort_now  = abort_pend | abort_i;
  assign dac_code_o = code;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= S_IDLE;
      code         <= '0;
      stop_r       <= '0;
      step_r       <= '0;
      navg_r       <= '0;
      acc          <= '0;
      cnt          <= '0;
      abort_pend   <= 1'b0;
      conv_start_o <= 1'b0;
      conv_ack_o   <= 1'b0;
      smp_valid_o  <= 1'b0;
      smp_code_o   <= '0;
      smp_data_o   <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      conv_start_o <= 1'b0;
      conv_ack_o   <= 1'b0;
      done_o       <= 1'b0;
      if (state != S_IDLE && abort_i) abort_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (go_i) begin
            code         <= code_start_i;
            stop_r       <= code_stop_i;
            step_r       <= code_step_i;
            navg_r       <= navg_clamp;
            acc          <= '0;
            cnt          <= '0;
            abort_pend   <= abort_i;
            busy_o       <= 1'b1;
            conv_start_o <= 1'b1;
            state        <= S_START;
          end
        end
        S_START: state <= S_WAIT_LO;
        S_WAIT_LO: if (!conv_eoc_i) state <= S_WAIT_HI;
        S_WAIT_HI: begin
          if (conv_eoc_i) begin
            conv_ack_o <= 1'b1;
            state      <= S_ACC;
          end
        end
        S_ACC: begin
          acc <= acc_sum;
          cnt <= cnt_inc;
          if (abort_now) begin
            done_o <= 1'b1;
            state  <= S_DONE;
          end else if (cnt_inc == cnt_target) begin
            smp_valid_o <= 1'b1;
            smp_code_o  <= code;
            smp_data_o  <= AW'(acc_sum >> navg_r);
            state       <= S_EMIT;
          end else begin
            conv_start_o <= 1'b1;
            state        <= S_START;
          end
        end
        S_EMIT: begin
          if (smp_ready_i) begin
            smp_valid_o <= 1'b0;
            state       <= S_NEXT;
          end
        end
        S_NEXT: begin
          acc <= '0;
          cnt <= '0;
          if (step_r == '0 || sum > {1'b0, stop_r} || abort_now) begin
            done_o <= 1'b1;
            state  <= S_DONE;
          end else begin
            code         <= sum[DW-1:0];
            conv_start_o <= 1'b1;
            state        <= S_START;
          end
        end
        S_DONE: begin
          acc        <= '0;
          cnt        <= '0;
          abort_pend <= 1'b0;
          busy_o     <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dac_sweep_ctrl.md
# dac_sweep_ctrl

Sequencer that drives the DAC→ADC single-conversion FSM through a programmable sweep of DAC codes for bolometer characterisation. For each sweep point it sets the DAC code, issues N back-to-back conversions, and accumulates the ADC results. It then presents the averaged sample with its DAC code to a downstream sink (FIFO/UART framer) over a valid/ready handshake. It sits between the host command registers and the conversion FSM: it drives that FSM's start and acknowledge inputs and reads its end-of-conversion flag and the ADC SIPO data.

## Interface
- DW, 12, DAC code width
- AW, 12, ADC sample width
- NL2, 4, max log2 of samples per point (N ≤ 2^NL2)

- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- go_i  in  1  start sweep; sampled only in IDLE
- abort_i  in  1  stop sweep at the next safe point
- code_start_i  in  DW  first DAC code
- code_stop_i  in  DW  last allowed DAC code
- code_step_i  in  DW  increment; 0 means single point
- navg_i  in  $clog2(NL2+1)  log2 samples per point; values > NL2 are clamped to NL2
- dac_code_o  out  DW  code applied to the DAC datapath
- conv_start_o  out  1  one-cycle pulse to the conversion FSM start
- conv_ack_o  out  1  one-cycle pulse releasing the conversion FSM final state (z)
- conv_eoc_i  in  1  conversion FSM end-of-conversion level (high when idle or finished)
- adc_data_i  in  AW  ADC result; valid while conv_eoc_i high after a conversion
- smp_valid_o  out  1  averaged sample available
- smp_ready_i  in  1  sink accepts the sample
- smp_code_o  out  DW  DAC code of the sample
- smp_data_o  out  AW  averaged ADC value
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse at sweep end, including after an abort

## Operation
- Reset values: all outputs 0; state IDLE; code, accumulator and count registers 0.
- Configuration inputs (start, stop, step, navg) are latched on the go_i edge. Later changes do not affect the running sweep.
- States and transitions:
  - IDLE: on go_i, latch config and set code = code_start_i → START.
  - START: conv_start_o=1 → WAIT_LO.
  - WAIT_LO: wait for conv_eoc_i=0 (conversion started) → WAIT_HI.
  - WAIT_HI: wait for conv_eoc_i=1 → ACC.
  - ACC: acc += adc_data_i; cnt += 1; conv_ack_o=1. Then:
    - if cnt reaches 2^navg → EMIT;
    - else → START.
  - EMIT: smp_valid_o=1 with smp_data_o = acc >> navg (truncate) and smp_code_o = code. Hold until smp_ready_i → NEXT.
  - NEXT: clear acc and cnt. Compute sum = code + step in DW+1 bits.
    - if step = 0, sum > code_stop, or abort is pending → DONE;
    - else code = sum[DW-1:0] → START.
  - DONE: done_o=1 → IDLE.
- Accumulator width is AW+NL2; it never overflows.
- dac_code_o follows the code register at all times and is stable from START through ACC.
- If code_start > code_stop, exactly one point (code_start) is measured.
- A code sum that overflows DW bits ends the sweep; there is no wrap-around.
- Abort handling:
  - abort_i is latched into a pending flag in any non-IDLE state.
  - An in-flight conversion always completes and is acknowledged in ACC.
  - After ACC, a pending abort forces → DONE, discarding the partial accumulation.
  - A pending abort in EMIT waits for the handshake, then → DONE.
  - abort_i in IDLE is ignored.
- go_i outside IDLE is ignored. go_i and abort_i together in IDLE: the sweep starts and aborts after the first conversion.
- Asserting rst_ni low mid-operation forces IDLE immediately. Any conversion then pending in the conversion FSM is cleared by that FSM's own reset, which shares the system reset.

## Timing
- go_i sampled high at cycle 0 → START at cycle 1: conv_start_o high and dac_code_o = code_start.
- Per-conversion overhead is 3 cycles beyond the conversion FSM latency: START, ACC, and WAIT_LO's detect cycle.
- ACC → EMIT at the next cycle. smp_valid_o stays high and smp_code_o/smp_data_o stay stable until the cycle where valid & ready.
- Handshake to next START takes 2 cycles (NEXT, START).
- done_o asserts 2 cycles after the final accepted handshake (NEXT, DONE). busy_o falls the cycle after done_o.

## Test plan
- Sweep start=0x100, stop=0x104, step=2, navg=0, ready tied high, conversion model returns code+1: expect 3 samples with (code, data) = (0x100,0x101), (0x102,0x103), (0x104,0x105); 3 conv_start_o and 3 conv_ack_o pulses; one done_o.
- navg=2, ADC returns 10, 11, 12, 13: one sample with data 11 (46>>2), 4 conversions, dac_code_o constant throughout.
- step=0x800, start=0xF00, DW=12: single point 0xF00, then DONE (overflow ends the sweep, no wrap); start=0x200 > stop=0x100 → single point 0x200.
- smp_ready_i low for 20 cycles in EMIT: valid and data held stable, no conv_start_o issued; the sweep resumes 2 cycles after ready goes high.
- abort_i pulsed during WAIT_HI of point 2: that conversion completes and is acked, no sample is emitted for point 2, done_o pulses, busy_o falls.
- rst_ni asserted in WAIT_LO: all outputs 0 immediately; a new go_i afterwards runs a full sweep normally.
